dco_nco_core: RTL and testbench
===============================

// Module: dco_nco_core
// PURPOSE
//   Digitally controlled oscillator (NCO style) for a Tiny Tapeout user tile.
//   An 8-bit frequency code on ui_in drives a 16-bit phase accumulator clocked by clk.
//   Outputs: square wave, overflow tick, divide-by-2 wave, coarse phase and an overflow counter.
//   Output frequency is FCW*f_clk/65536. Fully synchronous; no analog or ring-oscillator cells.
// PARAMETERS
//   ACC_W   16   phase accumulator width (FCW is zero-extended to ACC_W)
//   CNT_W    8   overflow counter width (mapped to uio_out)
// PORTS
//   clk      in   1  system clock, all state updates on rising edge
//   rst_n    in   1  reset, synchronous, active-low
//   ena      in   1  tile enable; 0 freezes all state
//   ui_in    in   8  FCW, frequency control word (unsigned)
//   uio_in   in   8  unused, ignored
//   uo_out   out  8  [0]=acc[15] square, [1]=ovf tick, [2]=div2 wave, [3]=fcw_zero, [7:4]=acc[15:12]
//   uio_out  out  8  overflow counter ovf_cnt[7:0]
//   uio_oe   out  8  constant 8'hFF (all uio driven as outputs)
// BEHAVIOUR
//   - Reset: on a clk edge with rst_n=0, acc=0, ovf=0, div2=0, ovf_cnt=0.
//     uo_out and uio_out read 0 in the cycle after the edge, except uo_out[3], which tracks ui_in.
//     Reset has priority over ena. Holding rst_n=0 for any duration keeps all state at 0.
//   - Step: on a clk edge with rst_n=1 and ena=1, compute {carry, acc_next} = acc + FCW (17-bit).
//     acc <= acc_next, with natural mod-2^16 wrap. ovf <= carry.
//     If carry=1: div2 <= ~div2 and ovf_cnt <= ovf_cnt + 1 (mod 256 wrap).
//   - Hold: rst_n=1, ena=0 -> acc, div2, ovf_cnt unchanged; ovf <= 0.
//   - uo_out[1] is a one-cycle pulse, registered. It is high in the cycle after the wrapping edge.
//   - uo_out[3] = (ui_in == 0), combinational. With FCW=0, acc is frozen and no ovf occurs.
//   - FCW change: the new code is used from the next edge. Phase is continuous: acc is not cleared, no glitch pulse.
//   - All other outputs are registered; ovf latency is 1 cycle from the accumulating edge.
//   - X-free: every register has a defined reset; uio_in is never read.
// TESTING
//   - Reset: rst_n=0 for 3 clk with FCW=8'h80 -> uo_out=8'h00, uio_out=8'h00, uio_oe=8'hFF.
//   - FCW=8'h80, ena=1 after reset:
//     uo_out[0] low 256 cycles then high 256; ovf pulse every 512 cycles.
//     uio_out increments 1 per 512 cycles.
//   - FCW=8'hFF: first ovf pulse after edge 258; acc=16'h00FE then; div2 toggles to 1.
//   - FCW=0: uo_out[3]=1, uo_out[7:4] frozen, no ovf for 1000 cycles.
//     Then set FCW=8'h01 -> uo_out[3]=0 next read, acc advances by 1 per cycle.
//   - Codes 01,02,04,...,80 applied for 200 clk each: acc increments by the current code each cycle, with no reset of phase.
//     Then rst_n=0 for one edge -> all zero; accumulation resumes from 0.
//   - ena=0 mid-run: acc and ovf_cnt hold, uo_out[1]=0. ena=1 resumes from the held value.
//     ovf_cnt wraps 8'hFF -> 8'h00.

Source files
------------

// File: rtl/dco_nco_core.sv
// dco_nco_core: NCO-style digitally controlled oscillator for a Tiny Tapeout tile.
// A 16-bit phase accumulator advances by an 8-bit frequency code every clock.
// The tile exposes a square wave, a one-cycle wrap tick, a divide-by-2 of the
// wrap events, a "code is zero" flag, the coarse phase and a wrap counter.
// Output frequency of the square wave is FCW * f_clk / 2^ACC_W.
module dco_nco_core #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             div2;
    logic [CNT_W-1:0] ovf_cnt;

    logic [ACC_W-1:0] fcw_ext;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             fcw_zero;

    // The bidirectional pins are always driven, so their input side carries no
    // information; it is folded into a dangling net and never used by logic.
    logic unused_uio_in;
    assign unused_uio_in = ^uio_in;

    // The frequency code is zero-extended and added with one extra bit so the
    // carry out of the top bit marks a phase wrap.
    always_comb begin
        fcw_ext  = {{(ACC_W-8){1'b0}}, ui_in};
        sum      = {1'b0, acc} + {1'b0, fcw_ext};
        carry    = sum[ACC_W];
        fcw_zero = (ui_in == 8'h00);
    end

    // Phase, wrap tick, divide-by-2 and wrap counter. Reset wins over enable;
    // with the tile disabled the phase state freezes and the tick is dropped
    // so no stale pulse is seen while frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            ovf     <= 1'b0;
            div2    <= 1'b0;
            ovf_cnt <= '0;
        end else if (ena) begin
            acc <= sum[ACC_W-1:0];
            ovf <= carry;
            if (carry) begin
                div2    <= ~div2;
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end else begin
            ovf <= 1'b0;
        end
    end

    // Output mapping. Everything except the zero-code flag comes straight from
    // registers; the flag follows ui_in immediately.
    always_comb begin
        uo_out  = {acc[ACC_W-1 -: 4], fcw_zero, div2, ovf, acc[ACC_W-1]};
        uio_out = ovf_cnt[7:0];
        uio_oe  = 8'hFF;
    end

endmodule

// File: tb/tb_dco_nco_core.sv
// tb_dco_nco_core: directed sequence for the NCO tile with a per-cycle
// scoreboard fed by an arithmetic reference model, plus fixed-value checks at
// the landmark cycles of each scenario.
module tb_dco_nco_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    dco_nco_core #(.ACC_W(16), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t        sb[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    int unsigned m_acc  = 0;
    bit          m_ovf  = 0;
    bit          m_div2 = 0;
    int unsigned m_cnt  = 0;
    int unsigned saved_cnt;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs and push what the outputs must be after the edge.
    task automatic apply_stimulus(input logic r, input logic e, input logic [7:0] f);
        exp_t x;
        rst_n  = r;
        ena    = e;
        ui_in  = f;
        uio_in = 8'($urandom_range(0, 255));
        if (!r) begin
            m_acc  = 0;
            m_ovf  = 0;
            m_div2 = 0;
            m_cnt  = 0;
        end else if (e) begin
            m_acc = m_acc + f;
            if (m_acc >= 65536) begin
                m_acc  = m_acc - 65536;
                m_ovf  = 1;
                m_div2 = !m_div2;
                m_cnt  = (m_cnt + 1) % 256;
            end else begin
                m_ovf = 0;
            end
        end else begin
            m_ovf = 0;
        end
        x.uo  = {m_acc[15:12], (f == 8'h00), m_div2, m_ovf, m_acc[15]};
        x.uio = m_cnt[7:0];
        sb.push_back(x);
    endtask

    task automatic check_output(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL %s.sb_empty: observed 0 entries expected 1", tag);
            return;
        end
        x = sb.pop_front();
        check_val({tag, ".uo_out"},  uo_out,  x.uo);
        check_val({tag, ".uio_out"}, uio_out, x.uio);
        check_val({tag, ".uio_oe"},  uio_oe,  8'hFF);
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] f, input string tag);
        apply_stimulus(r, e, f);
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h80;
        uio_in = 8'h00;
        #2;

        // Reset held three edges with a nonzero code.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h80, "reset");
        check_val("reset_uo",  uo_out,  8'h00);
        check_val("reset_uio", uio_out, 8'h00);
        check_val("reset_oe",  uio_oe,  8'hFF);

        // Half-scale code: 256 cycles low, 256 high, one tick per 512 cycles.
        for (int k = 1; k <= 1024; k++) begin
            step(1'b1, 1'b1, 8'h80, "fcw80");
            if (k == 255)  check_val("fcw80_sq_255",  {7'd0, uo_out[0]}, 8'h00);
            if (k == 256)  check_val("fcw80_sq_256",  {7'd0, uo_out[0]}, 8'h01);
            if (k == 511)  check_val("fcw80_sq_511",  {7'd0, uo_out[0]}, 8'h01);
            if (k == 512)  check_val("fcw80_k512_uo", uo_out, 8'h06);
            if (k == 512)  check_val("fcw80_k512_cnt", uio_out, 8'h01);
            if (k == 513)  check_val("fcw80_tick_513", {7'd0, uo_out[1]}, 8'h00);
            if (k == 1024) check_val("fcw80_k1024_cnt", uio_out, 8'h02);
            if (k == 1024) check_val("fcw80_k1024_uo", uo_out, 8'h02);
        end

        // Max code: first wrap on edge 258 leaves acc at 0x00FE.
        step(1'b0, 1'b1, 8'hFF, "rst_ff");
        for (int k = 1; k <= 258; k++) begin
            step(1'b1, 1'b1, 8'hFF, "fcwff");
            if (k == 257) check_val("fcwff_k257_uo", uo_out, 8'hF1);
            if (k == 258) check_val("fcwff_k258_uo", uo_out, 8'h06);
            if (k == 258) check_val("fcwff_k258_cnt", uio_out, 8'h01);
        end

        // Zero code freezes phase; then a code of 1 advances it by one per edge.
        for (int k = 1; k <= 1000; k++) step(1'b1, 1'b1, 8'h00, "fcw00");
        check_val("fcw00_frozen_uo", uo_out, 8'h0C);
        check_val("fcw00_cnt", uio_out, 8'h01);
        step(1'b1, 1'b1, 8'h01, "fcw01");
        check_val("fcw01_first_uo", uo_out, 8'h04);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 8'h01, "fcw01");

        // Walking-one codes with continuous phase, then a single reset edge.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 200; k++) step(1'b1, 1'b1, 8'(1 << i), "walk");
        end
        step(1'b0, 1'b1, 8'h80, "walk_rst");
        check_val("walk_rst_uo",  uo_out,  8'h00);
        check_val("walk_rst_uio", uio_out, 8'h00);
        for (int k = 0; k < 40; k++) step(1'b1, 1'b1, 8'hC3, "resume");

        // Drop enable right after a wrap: tick clears, phase and count hold.
        for (int k = 0; k < 1000 && !m_ovf; k++) step(1'b1, 1'b1, 8'h9D, "pre_hold");
        check_val("pre_hold_tick", {7'd0, uo_out[1]}, 8'h01);
        saved_cnt = m_cnt;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 8'h9D, "hold");
            if (k == 0)  check_val("hold_tick", {7'd0, uo_out[1]}, 8'h00);
            if (k == 19) check_val("hold_cnt", uio_out, saved_cnt[7:0]);
        end
        for (int k = 0; k < 600; k++) step(1'b1, 1'b1, 8'h9D, "post_hold");

        // Counter wrap: 256 wraps at max code need 65794 edges from zero.
        step(1'b0, 1'b1, 8'hFF, "rst_wrap");
        for (int k = 1; k <= 65794; k++) begin
            step(1'b1, 1'b1, 8'hFF, "cntwrap");
            if (k == 65793) check_val("cntwrap_ff", uio_out, 8'hFF);
            if (k == 65794) check_val("cntwrap_00", uio_out, 8'h00);
            if (k == 65794) check_val("cntwrap_tick", {7'd0, uo_out[1]}, 8'h01);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
